// File: rtl/barcode_tx.sv
`default_nettype none
// ============================================================================
//  Module   : barcode_tx
//  Purpose  : Serial barcode transmitter. Sends an 8-bit station ID, MSB
//             first, after a start cell. Every cell is 4*q clocks long and
//             begins with a falling edge of BC. A '1' is low q and high 3q,
//             a '0' is low 3q and high q, and the start cell is low 2q and
//             high 2q.
//  Options  : BARCODE_TX_ID_CHECK_EN - reject IDs with ID[7:6] != 2'b00
//             by pulsing err instead of starting a frame.
//  Revision : 1.0 - initial release
// ============================================================================
module barcode_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send,
  input  logic [7:0]  ID,
  input  logic [19:0] quarter,
  output logic        BC,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START_LO = 3'd1,
    START_HI = 3'd2,
    BIT_LO   = 3'd3,
    BIT_HI   = 3'd4
  } state_t;

  state_t      r_state;
  logic [21:0] r_timer;     // clocks elapsed in the current phase
  logic [2:0]  r_bit_cnt;   // index of the data cell being sent
  logic [7:0]  r_shift;     // r_shift[7] is the bit currently on the line
  logic [19:0] r_hold;      // quarter-cell length latched for this frame

  logic [21:0] w_q1;
  logic [21:0] w_q2;
  logic [21:0] w_q3;
  logic [21:0] w_phase_last;
  logic        w_phase_end;
  logic        w_send_ok;
  logic        w_id_bad;

  // 22 bits hold 3 * (2^20 - 1) without overflow, so no phase ever wraps
  assign w_q1 = {2'b00, r_hold};
  assign w_q2 = {1'b0, r_hold, 1'b0};
  assign w_q3 = w_q1 + w_q2;

  // Last timer value of the current phase (phase length minus one)
  always_comb begin
    w_phase_last = '0;
    case (r_state)
      START_LO, START_HI: w_phase_last = w_q2 - 22'd1;
      BIT_LO:             w_phase_last = (r_shift[7] ? w_q1 : w_q3) - 22'd1;
      BIT_HI:             w_phase_last = (r_shift[7] ? w_q3 : w_q1) - 22'd1;
      default:            w_phase_last = '0;
    endcase
  end

  assign w_phase_end = (r_timer == w_phase_last);

  // A request on the done cycle is dropped so frames are separated by at
  // least one idle cycle; a zero quarter would give a degenerate frame.
  assign w_send_ok = send && (quarter != 20'd0) && !done;

`ifdef BARCODE_TX_ID_CHECK_EN
  assign w_id_bad = (ID[7:6] != 2'b00);
`else
  assign w_id_bad = 1'b0;
`endif

  // Frame sequencer with registered BC/busy/done/err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_hold    <= '0;
      BC        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          if (w_send_ok) begin
            if (w_id_bad) begin
              err <= 1'b1;
            end else begin
              r_shift   <= ID;
              r_hold    <= quarter;
              r_bit_cnt <= '0;
              r_state   <= START_LO;
              BC        <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end

        START_LO: begin
          if (w_phase_end) begin
            r_timer <= '0;
            r_state <= START_HI;
            BC      <= 1'b1;
          end else begin
            r_timer <= r_timer + 22'd1;
          end
        end

        START_HI: begin
          if (w_phase_end) begin
            r_timer <= '0;
            r_state <= BIT_LO;
            BC      <= 1'b0;
          end else begin
            r_timer <= r_timer + 22'd1;
          end
        end

        BIT_LO: begin
          if (w_phase_end) begin
            r_timer <= '0;
            r_state <= BIT_HI;
            BC      <= 1'b1;
          end else begin
            r_timer <= r_timer + 22'd1;
          end
        end

        BIT_HI: begin
          if (w_phase_end) begin
            r_timer <= '0;
            r_shift <= {r_shift[6:0], 1'b0};
            if (r_bit_cnt == 3'd7) begin
              r_state <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_state   <= BIT_LO;
              BC        <= 1'b0;
            end
          end else begin
            r_timer <= r_timer + 22'd1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_timer <= '0;
          BC      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_barcode_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_barcode_tx
//  Purpose  : Self-checking bench for barcode_tx. Expected waveforms are
//             built from the cell rules (start 2q/2q, '1' q/3q, '0' 3q/q).
//  Options  : honours BARCODE_TX_ID_CHECK_EN like the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_barcode_tx;

  logic        clk;
  logic        rst_n;
  logic        send;
  logic [7:0]  id;
  logic [19:0] quarter;
  logic        bc;
  logic        busy;
  logic        done;
  logic        err;

  int vectors;
  int miscompares;

  logic exp_bc[$];
  logic obs_bc[$];
  int   done_at;
  int   busy_bad;
  int   err_seen;

  barcode_tx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .send    (send),
    .ID      (id),
    .quarter (quarter),
    .BC      (bc),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck run still terminates
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected BC per clock, from first low cycle up to (not incl.) done
  function automatic void build_expected(input logic [7:0] id_v, input int q);
    int lo;
    exp_bc.delete();
    repeat (2 * q) exp_bc.push_back(1'b0);
    repeat (2 * q) exp_bc.push_back(1'b1);
    for (int b = 7; b >= 0; b--) begin
      lo = id_v[b] ? q : 3 * q;
      repeat (lo) exp_bc.push_back(1'b0);
      repeat (4 * q - lo) exp_bc.push_back(1'b1);
    end
  endfunction

  function automatic int first_diff();
    int n;
    n = (exp_bc.size() < obs_bc.size()) ? exp_bc.size() : obs_bc.size();
    for (int i = 0; i < n; i++)
      if (exp_bc[i] !== obs_bc[i]) return i;
    if (exp_bc.size() != obs_bc.size()) return n;
    return -1;
  endfunction

  function automatic logic [7:0] legal_id();
    logic [7:0] v;
    v = 8'($urandom);
`ifdef BARCODE_TX_ID_CHECK_EN
    v[7:6] = 2'b00;
`endif
    return v;
  endfunction

  // All tasks start and end at posedge+1
  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] id_v, input int q);
    send    = 1'b1;
    id      = id_v;
    quarter = 20'(q);
    idle_cycle();
    send    = 1'b0;
  endtask

  // Record BC each cycle until done; optionally inject a foreign request
  task automatic capture(input int max, input int inj_at);
    obs_bc.delete();
    done_at  = -1;
    busy_bad = 0;
    err_seen = 0;
    for (int i = 0; i < max; i++) begin
      if (done === 1'b1) begin
        done_at = i;
        break;
      end
      obs_bc.push_back(bc);
      if (busy !== 1'b1) busy_bad++;
      if (err !== 1'b0) err_seen++;
      if (i == inj_at) begin
        send    = 1'b1;
        id      = 8'h3F;
        quarter = 20'd7;
      end else begin
        send = 1'b0;
      end
      idle_cycle();
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    send    = 1'b0;
    id      = 8'h00;
    quarter = 20'd0;
    repeat (3) idle_cycle();
    vectors++;
    if ({bc, busy, done, err} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected 1000", {bc, busy, done, err});
    end
    rst_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_frames();
    logic [7:0] id_v;
    int q;
    int d;
    for (int n = 0; n < 6; n++) begin
      if (n == 0) begin id_v = 8'h2A; q = 4; end
      else if (n == 1) begin id_v = 8'h00; q = 1; end
      else begin id_v = legal_id(); q = int'($urandom_range(1, 5)); end
      build_expected(id_v, q);
      start_frame(id_v, q);
      capture(36 * q + 20, -1);
      d = first_diff();
      vectors++;
      if (d != -1) begin
        miscompares++;
        $display("FAIL frame_wave id=%h q=%0d: first difference at cycle %0d (got %0d samples, expected %0d)",
                 id_v, q, d, obs_bc.size(), exp_bc.size());
      end
      vectors++;
      if (done_at != 36 * q) begin
        miscompares++;
        $display("FAIL frame_done id=%h q=%0d: done at %0d expected %0d", id_v, q, done_at, 36 * q);
      end
      vectors++;
      if (busy_bad != 0 || err_seen != 0 || bc !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL frame_flags id=%h q=%0d: busy_low=%0d err=%0d end_bc=%b end_busy=%b expected 0 0 1 0",
                 id_v, q, busy_bad, err_seen, bc, busy);
      end
      idle_cycle();
    end
  endtask

  task automatic test_quarter_zero();
    int bad;
    bad     = 0;
    send    = 1'b1;
    id      = 8'hC1;
    quarter = 20'd0;
    idle_cycle();
    send = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || bc !== 1'b1 || err !== 1'b0 || done !== 1'b0) bad++;
      idle_cycle();
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL quarter_zero: %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_midframe_send();
    int d;
    int bad;
    build_expected(8'h15, 3);
    start_frame(8'h15, 3);
    capture(150, 20);
    d = first_diff();
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("FAIL midframe_wave: first difference at cycle %0d expected none", d);
    end
    vectors++;
    if (done_at != 108) begin
      miscompares++;
      $display("FAIL midframe_done: done at %0d expected 108", done_at);
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      idle_cycle();
      if (busy !== 1'b0 || bc !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL midframe_not_queued: %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] id1;
    logic [7:0] id2;
    int d;
    id1 = legal_id();
    id2 = legal_id();
    start_frame(id1, 2);
    capture(100, -1);
    vectors++;
    if (done_at != 72) begin
      miscompares++;
      $display("FAIL b2b_first_done: done at %0d expected 72", done_at);
    end
    // Request held over the done cycle and the following one
    send    = 1'b1;
    id      = id2;
    quarter = 20'd3;
    idle_cycle();
    vectors++;
    if ({busy, bc} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_done_cycle_ignored: busy,bc=%b expected 01", {busy, bc});
    end
    idle_cycle();
    send = 1'b0;
    build_expected(id2, 3);
    capture(130, -1);
    d = first_diff();
    vectors++;
    if (d != -1 || done_at != 108) begin
      miscompares++;
      $display("FAIL b2b_second_frame: first difference %0d done at %0d expected -1 and 108", d, done_at);
    end
    idle_cycle();
  endtask

  task automatic test_reset_midframe();
    int d;
    start_frame(legal_id(), 2);
    repeat (4 * 2 + 4 * 4 * 2 + 2) idle_cycle();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_busy: busy=%b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bc, busy, done} !== 3'b100) begin
      miscompares++;
      $display("FAIL rst_mid_immediate: bc,busy,done=%b expected 100", {bc, busy, done});
    end
    idle_cycle();
    rst_n = 1'b1;
    repeat (3) idle_cycle();
    vectors++;
    if ({bc, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL rst_mid_no_resume: bc,busy=%b expected 10", {bc, busy});
    end
    build_expected(8'h01, 2);
    start_frame(8'h01, 2);
    capture(100, -1);
    d = first_diff();
    vectors++;
    if (d != -1 || done_at != 72) begin
      miscompares++;
      $display("FAIL rst_mid_fresh_frame: first difference %0d done at %0d expected -1 and 72", d, done_at);
    end
    idle_cycle();
  endtask

  task automatic test_id_check();
`ifdef BARCODE_TX_ID_CHECK_EN
    int bad;
    start_frame(8'hC1, 2);
    vectors++;
    if ({err, busy, bc} !== 3'b101) begin
      miscompares++;
      $display("FAIL idchk_reject: err,busy,bc=%b expected 101", {err, busy, bc});
    end
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      idle_cycle();
      if (err !== 1'b0 || busy !== 1'b0 || bc !== 1'b1 || done !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL idchk_quiet: %0d active cycles expected 0", bad);
    end
`else
    int d;
    build_expected(8'hC1, 2);
    start_frame(8'hC1, 2);
    capture(100, -1);
    d = first_diff();
    vectors++;
    if (d != -1 || done_at != 72) begin
      miscompares++;
      $display("FAIL idchk_frame: first difference %0d done at %0d expected -1 and 72", d, done_at);
    end
    vectors++;
    if (err_seen != 0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL idchk_err: err cycles %0d expected 0", err_seen);
    end
    idle_cycle();
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_frames();
    test_quarter_zero();
    test_midframe_send();
    test_back_to_back();
    test_reset_midframe();
    test_id_check();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/barcode_tx.md
BARCODE_TX -- requirements
Module: barcode_tx

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; ports clk and rst_n.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 send  input  1  single-cycle request to transmit ID; sampled only in IDLE.
REQ-005 ID  input  8  station ID to transmit, MSB first; captured on accepted send.
REQ-006 quarter  input  20  quarter-bit-cell length in clk cycles; captured on accepted send.
REQ-007 BC  output  1  serial barcode waveform, registered; idle high (non-black).
REQ-008 busy  output  1  high while a frame is in progress.
REQ-009 done  output  1  one-cycle pulse at frame end.
REQ-010 err  output  1  one-cycle reject pulse (see Configuration); constant 0 when feature compiled out.

Function
REQ-011 States SHALL be IDLE, START_LO, START_HI, BIT_LO, BIT_HI.
REQ-012 Accepted send (IDLE, send=1, quarter!=0) SHALL latch ID into a shift register and quarter into a hold register, clear the bit counter, and enter START_LO; BC low and busy high from the next cycle.
REQ-013 send with quarter==0 SHALL be ignored: no state change, no err.
REQ-014 send while busy SHALL be ignored; ID/quarter changes mid-frame SHALL NOT affect the frame.
REQ-015 Start bit: BC low 2*q cycles (START_LO), then high 2*q cycles (START_HI); q = latched quarter.
REQ-016 Data bit 1: BC low q cycles (BIT_LO), then high 3*q cycles (BIT_HI).
REQ-017 Data bit 0: BC low 3*q cycles, then high q cycles.
REQ-018 Every bit cell SHALL be exactly 4*q cycles; each cell SHALL start with a BC falling edge.
REQ-019 Bits SHALL be sent ID[7] first; shift register SHALL shift left once per completed cell.
REQ-020 Phase timer SHALL be 22 bits, counting from 0 to phase length minus 1, then resetting at the phase transition; no wrap within a phase for any legal quarter.
REQ-021 After the 8th BIT_HI phase completes: next state IDLE, busy low, done high for exactly that one cycle, BC remains high.
REQ-022 Total frame length SHALL be 36*q cycles from first BC-low cycle to done.
REQ-023 A send asserted in the same cycle as done SHALL be ignored; a send one cycle later SHALL be accepted (back-to-back frames, minimum 1 idle cycle).
REQ-024 BC SHALL never glitch: it changes only at phase boundaries.

Reset
REQ-025 rst_n low SHALL immediately force BC=1, busy=0, done=0, err=0, state IDLE, timer, bit counter, shift and hold registers to 0, aborting any frame in progress.
REQ-026 After reset release, the first send SHALL be accepted normally; no partial frame SHALL resume.

Configuration
REQ-027 Macro BARCODE_TX_ID_CHECK_EN SHALL compile in ID validity checking.
REQ-028 Defined: send in IDLE with quarter!=0 and ID[7:6]!=2'b00 SHALL be rejected -- err pulses one cycle next clock, state stays IDLE, BC stays high, busy stays low.
REQ-029 Undefined: every ID is transmitted; err tied to 0.

Verification
REQ-030 quarter=4, ID=0x2A, send pulse -> BC low 8/high 8, then cells 0,0,1,0,1,0,1,0 (bit1: low 4/high 12; bit0: low 12/high 4); done at cycle 144 after first BC low.
REQ-031 quarter=1, ID=0x00 -> 36-cycle frame, each data cell low 3/high 1; BC sampled 2 cycles after each falling edge reads 0.
REQ-032 Mid-frame send with ID=0x3F and quarter=7 during ID=0x15, quarter=3 frame -> frame unaffected, 108 cycles, second request not queued.
REQ-033 rst_n pulsed low during bit 4 -> BC=1, busy=0 same cycle; next send ID=0x01 sends full fresh frame.
REQ-034 ID=0xC1, quarter=2: macro defined -> err pulse, BC stays high, no done; macro undefined -> normal 72-cycle frame, err stays 0.
REQ-035 quarter=0 send -> no activity, busy=0; send asserted on done cycle ignored, send one cycle later accepted.
